window_scan_ctrl: RTL and testbench

Scan sequencer for the 3x3 image-filter datapath. On a start pulse it reads the padded source image in raster order, (IMG_H+2) x (IMG_W+2) pixels, one per cycle. It tells the window/line-buffer datapath when to shift. It also delays the window-valid flag and the destination coordinates through a PIPE_LAT-deep tag pipe, producing write strobes and addresses for the filtered-image memory (IMG_H x IMG_W). It sits between `top_level`'s start control and the padded/filtered image memories.

---
 rtl/window_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster scan sequencer for the 3x3 image-filter datapath.
// Reads the padded (IMG_H+2)x(IMG_W+2) image one pixel per cycle. Drives the
// window shift and delays the window-valid tag through a PIPE_LAT-deep pipe,
// so the filtered write strobe and address line up with the datapath output.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   en                start request, sampled only in IDLE
//   hold              freeze request from datapath/memory
//   rd_en/rd_row/col  padded image read strobe and coordinates
//   shift_en          datapath advance (window shift and pipe stages)
//   wr_en/wr_row/col  filtered image write strobe and coordinates
//   busy, done        frame in progress / one-cycle completion pulse
module window_scan_ctrl #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned RA_W     = 9,
  parameter int unsigned WA_W     = 8,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            hold,
  output logic            rd_en,
  output logic [RA_W-1:0] rd_row,
  output logic [RA_W-1:0] rd_col,
  output logic            shift_en,
  output logic            wr_en,
  output logic [WA_W-1:0] wr_row,
  output logic [WA_W-1:0] wr_col,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned LAST  = PIPE_LAT - 1;

  localparam logic [RA_W-1:0]  COL_LAST = RA_W'(IMG_W + 1);
  localparam logic [RA_W-1:0]  ROW_LAST = RA_W'(IMG_H + 1);
  localparam logic [RA_W-1:0]  TWO      = RA_W'(2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RA_W-1:0]   row_q, col_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              vld_q  [PIPE_LAT];
  logic [WA_W-1:0]   trow_q [PIPE_LAT];
  logic [WA_W-1:0]   tcol_q [PIPE_LAT];

  logic              tag_vld;
  logic [WA_W-1:0]   tag_row, tag_col;
  logic              last_read;

  assign last_read = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state and control strobes; hold freezes everything except DONE.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    shift_en = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    case (state_q)
      IDLE: if (en) state_d = SCAN;
      SCAN: begin
        if (!hold) begin
          rd_en    = 1'b1;
          shift_en = 1'b1;
          if (last_read) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!hold) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window is complete once two padded rows and columns have been seen.
  always_comb begin
    tag_vld = rd_en && (row_q >= TWO) && (col_q >= TWO);
    tag_row = '0;
    tag_col = '0;
    if (tag_vld) begin
      tag_row = WA_W'(row_q - TWO);
      tag_col = WA_W'(col_q - TWO);
    end
  end

  // State, read counters and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && en) begin
        row_q <= '0;
        col_q <= '0;
        cnt_q <= '0;
      end else if (state_q == SCAN && !hold) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          // Row stays put after the final read so it never overflows RA_W.
          if (row_q != ROW_LAST) row_q <= row_q + RA_W'(1);
        end else begin
          col_q <= col_q + RA_W'(1);
        end
      end else if (state_q == DRAIN && !hold) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Tag pipe advances in lockstep with the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        vld_q[i]  <= 1'b0;
        trow_q[i] <= '0;
        tcol_q[i] <= '0;
      end
    end else if (shift_en) begin
      vld_q[0]  <= tag_vld;
      trow_q[0] <= tag_row;
      tcol_q[0] <= tag_col;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        vld_q[i]  <= vld_q[i-1];
        trow_q[i] <= trow_q[i-1];
        tcol_q[i] <= tcol_q[i-1];
      end
    end
  end

  assign rd_row = row_q;
  assign rd_col = col_q;
  assign wr_en  = vld_q[LAST] && shift_en;
  assign wr_row = trow_q[LAST];
  assign wr_col = tcol_q[LAST];

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl on a reduced image. The reference model works in
// "advancing steps": every non-held busy cycle consumes one step; step s < N is
// the raster read s, and step s carries the write of read s-PIPE_LAT.
module tb_window_scan_ctrl;

  localparam int unsigned W    = 12;
  localparam int unsigned H    = 6;
  localparam int unsigned RA_W = 4;
  localparam int unsigned WA_W = 4;
  localparam int unsigned P    = 3;
  localparam int CW = W + 2;
  localparam int N  = (H + 2) * (W + 2);

  logic            clk, rst, en, hold;
  logic            rd_en, shift_en, wr_en, busy, done;
  logic [RA_W-1:0] rd_row, rd_col;
  logic [WA_W-1:0] wr_row, wr_col;

  int checks   = 0;
  int failures = 0;

  window_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .RA_W(RA_W), .WA_W(WA_W), .PIPE_LAT(P)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .shift_en(shift_en), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write produced at step s, if any, with its filtered coordinates.
  function automatic bit write_at(input int s, output int r, output int c);
    int j;
    j = s - int'(P);
    r = 0;
    c = 0;
    if (j < 0 || j >= N) return 1'b0;
    if (j / CW < 2 || j % CW < 2) return 1'b0;
    r = j / CW - 2;
    c = j % CW - 2;
    return 1'b1;
  endfunction

  // One frame against the step model. en_mode: 0 low, 1 random, 2 held high.
  task automatic run_frame(input string name, input int hold_pct, input int en_mode);
    int s = 0;
    int rds = 0;
    int wrs = 0;
    int er, ec;
    bit finished = 1'b0;
    bit exp_rd, exp_wr;
    logic [4:0] got, exp;
    @(negedge clk);
    en = 1'b1;
    hold = 1'b0;
    #1;
    checks++;
    got = {rd_en, shift_en, wr_en, busy, done};
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL %s idle_before_start got=%b exp=00000", name, got);
    end
    for (int cyc = 0; cyc < 4 * (N + int'(P)) + 20 && !finished; cyc++) begin
      @(negedge clk);
      en   = (en_mode == 2) ? 1'b1 : (en_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      hold = ($urandom_range(99, 0) < hold_pct);
      #1;
      exp_rd = 1'b0;
      exp_wr = 1'b0;
      er = 0;
      ec = 0;
      if (s == N + int'(P)) begin
        exp = 5'b00011;
        finished = 1'b1;
      end else if (hold) begin
        exp = 5'b00010;
      end else begin
        exp_rd = (s < N);
        exp_wr = write_at(s, er, ec);
        exp = {exp_rd, 1'b1, exp_wr, 1'b1, 1'b0};
      end
      got = {rd_en, shift_en, wr_en, busy, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s ctl step=%0d got=%b exp=%b", name, s, got, exp);
      end
      if (exp_rd) begin
        checks++;
        if (rd_row !== RA_W'(s / CW) || rd_col !== RA_W'(s % CW)) begin
          failures++;
          $display("FAIL %s rd_addr step=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                   name, s, rd_row, rd_col, s / CW, s % CW);
        end
      end
      if (exp_wr) begin
        checks++;
        if (wr_row !== WA_W'(er) || wr_col !== WA_W'(ec)) begin
          failures++;
          $display("FAIL %s wr_addr step=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                   name, s, wr_row, wr_col, er, ec);
        end
      end
      if (rd_en === 1'b1) rds++;
      if (wr_en === 1'b1) wrs++;
      if (!finished && !hold) s++;
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s timeout got_step=%0d exp_step=%0d", name, s, N + int'(P));
    end
    checks++;
    if (rds != N) begin
      failures++;
      $display("FAIL %s read_count got=%0d exp=%0d", name, rds, N);
    end
    checks++;
    if (wrs != int'(H * W)) begin
      failures++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wrs, H * W);
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = ~en;
      #1;
      got = {rd_en, shift_en, wr_en, busy, done};
      checks++;
      if (got !== 5'b00000 || rd_row !== '0 || rd_col !== '0 || wr_row !== '0 || wr_col !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=00000", i, got);
      end
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got busy=%b rd_en=%b exp 0 0", busy, rd_en);
    end
  endtask

  task automatic test_frame_nohold();
    run_frame("frame_nohold", 0, 0);
  endtask

  task automatic test_hold();
    run_frame("frame_hold", 30, 0);
  endtask

  task automatic test_en_ignored();
    run_frame("frame_en_noise", 20, 1);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 0, 2);
    run_frame("b2b_second", 15, 2);
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b rd_en=%b exp 0 0", busy, rd_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stay_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] got;
    @(negedge clk);
    en = 1'b1;
    hold = 1'b0;
    repeat (2 * CW + 10) begin
      @(negedge clk);
      en = 1'b0;
    end
    rst = 1'b0;
    #1;
    got = {rd_en, shift_en, wr_en, busy, done};
    checks++;
    if (got !== 5'b00000 || wr_row !== '0 || wr_col !== '0 || rd_row !== '0 || rd_col !== '0) begin
      failures++;
      $display("FAIL midframe_reset got=%b rd=(%0d,%0d) wr=(%0d,%0d) exp all 0",
               got, rd_row, rd_col, wr_row, wr_col);
    end
    repeat (2) begin
      @(negedge clk);
      en = ~en;
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hold = 1'($urandom_range(1, 0));
      #1;
      checks++;
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d got wr=%b rd=%b busy=%b exp 0 0 0",
                 i, wr_en, rd_en, busy);
      end
    end
    hold = 1'b0;
    run_frame("after_reset", 10, 0);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    hold = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_frame_nohold();
    test_hold();
    test_en_ignored();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
